// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvp_pkg
// Purpose  : State encoding and RGB565 colour-bar constants for dvp_frame_tx
// Revision : 1.0
// ============================================================================
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } state_t;

    localparam logic [15:0] c_BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] c_BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] c_BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] c_BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] c_BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] c_BAR_RED     = 16'hF800;
    localparam logic [15:0] c_BAR_BLUE    = 16'h001F;
    localparam logic [15:0] c_BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] color;
        case (idx)
            3'd0:    color = c_BAR_WHITE;
            3'd1:    color = c_BAR_YELLOW;
            3'd2:    color = c_BAR_CYAN;
            3'd3:    color = c_BAR_GREEN;
            3'd4:    color = c_BAR_MAGENTA;
            3'd5:    color = c_BAR_RED;
            3'd6:    color = c_BAR_BLUE;
            default: color = c_BAR_BLACK;
        endcase
        return color;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : dvp_timing_gen
// Purpose  : pclk divider, line/frame counters and frame state machine
// Revision : 1.0
// ============================================================================
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int H_W         = 11,
    parameter int V_W         = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    output state_t         state,
    output logic [H_W-1:0] h_cnt,
    output logic           launch,
    output logic           start,
    output logic           frame_done,
    output logic           pclk,
    output logic           href,
    output logic           vsync,
    output logic           frame_start
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int V_TOTAL  = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [H_W-1:0] c_H_LAST   = H_W'(LINE_LEN - 1);
    localparam logic [H_W-1:0] c_H_ACT    = H_W'(2 * H_ACTIVE);
    localparam logic [V_W-1:0] c_V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] c_V_BACK0  = V_W'(VSYNC_LINES);
    localparam logic [V_W-1:0] c_V_ACT0   = V_W'(VSYNC_LINES + V_BACK);
    localparam logic [V_W-1:0] c_V_FRONT0 = V_W'(VSYNC_LINES + V_BACK + V_ACTIVE);

    state_t         r_state;
    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic           r_pclk_q;
    logic           r_href;
    logic           r_vsync;
    logic           r_frame_start;

    logic           w_launch;
    logic           w_h_last;
    logic           w_v_last;
    logic [V_W-1:0] w_v_nxt;

    // state/h_cnt/v_cnt name the position that the next launch edge will drive
    assign w_launch = r_pclk_q && (r_state != IDLE);
    assign w_h_last = (r_h_cnt == c_H_LAST);
    assign w_v_last = (r_v_cnt == c_V_LAST);
    assign w_v_nxt  = r_v_cnt + V_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_pclk_q      <= 1'b0;
            r_href        <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (r_state == IDLE) begin
                r_pclk_q <= 1'b0;
                if (enable) begin
                    r_state  <= VSYNC;
                    r_h_cnt  <= '0;
                    r_v_cnt  <= '0;
                    r_pclk_q <= 1'b1;
                end
            end else begin
                r_pclk_q <= ~r_pclk_q;
                if (r_pclk_q) begin
                    r_vsync       <= (r_state == VSYNC);
                    r_href        <= (r_state == ACTIVE) && (r_h_cnt < c_H_ACT);
                    r_frame_start <= (r_state == VSYNC) && (r_h_cnt == '0) && (r_v_cnt == '0);
                    if (w_h_last) begin
                        r_h_cnt <= '0;
                        if (w_v_last) begin
                            r_v_cnt <= '0;
                            r_state <= enable ? VSYNC : IDLE;
                        end else begin
                            r_v_cnt <= w_v_nxt;
                            if (w_v_nxt == c_V_BACK0)
                                r_state <= VBACK;
                            else if (w_v_nxt == c_V_ACT0)
                                r_state <= ACTIVE;
                            else if (w_v_nxt == c_V_FRONT0)
                                r_state <= VFRONT;
                        end
                    end else begin
                        r_h_cnt <= r_h_cnt + H_W'(1);
                    end
                end
            end
        end
    end

    assign state       = r_state;
    assign h_cnt       = r_h_cnt;
    assign launch      = w_launch;
    assign start       = (r_state == IDLE) && enable;
    assign frame_done  = w_launch && w_h_last && w_v_last;
    assign pclk        = r_pclk_q;
    assign href        = r_href;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: rtl/dvp_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : dvp_frame_tx
// Purpose  : OV7670-style DVP transmitter (RGB565, high byte first).
//            DVP_TX_TEST_PATTERN_EN adds pattern_sel and an 8-bar generator.
// Revision : 1.0
// ============================================================================
module dvp_frame_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cmos_pclk,
    output logic        cmos_href,
    output logic        cmos_vsync,
    output logic [7:0]  cmos_db,
    output logic        frame_start,
    output logic        underflow,
    output logic [15:0] frame_cnt
);

    localparam int H_W = $clog2(2 * H_ACTIVE + H_BLANK);
    localparam int V_W = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);
    localparam logic [H_W-1:0] c_H_ACT = H_W'(2 * H_ACTIVE);

    state_t         w_state;
    logic [H_W-1:0] w_h_cnt;
    logic           w_launch;
    logic           w_start;
    logic           w_frame_done;
    logic           w_frame_start;
    logic           w_act_byte;
    logic           w_even;
    logic           w_use_pat;
    logic [15:0]    w_pat_pix;

    logic [7:0]     r_db;
    logic [15:0]    r_pix_q;
    logic           r_underflow;
    logic [15:0]    r_frame_cnt;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .H_W         (H_W),
        .V_W         (V_W)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .state       (w_state),
        .h_cnt       (w_h_cnt),
        .launch      (w_launch),
        .start       (w_start),
        .frame_done  (w_frame_done),
        .pclk        (cmos_pclk),
        .href        (cmos_href),
        .vsync       (cmos_vsync),
        .frame_start (w_frame_start)
    );

`ifdef DVP_TX_TEST_PATTERN_EN
    logic       r_pat_mode;
    logic [2:0] w_bar_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pat_mode <= 1'b0;
        else if (w_frame_start)
            r_pat_mode <= pattern_sel;
    end

    // bar index from pixel column; out-of-range values only occur in blanking
    assign w_bar_idx = 3'((int'(w_h_cnt >> 1) * 8) / H_ACTIVE);
    assign w_use_pat = r_pat_mode;
    assign w_pat_pix = bar_color(w_bar_idx);
`else
    assign w_use_pat = 1'b0;
    assign w_pat_pix = 16'h0000;
`endif

    assign w_act_byte = (w_state == ACTIVE) && (w_h_cnt < c_H_ACT);
    assign w_even     = ~w_h_cnt[0];
    assign pix_ready  = w_launch && w_act_byte && w_even && !w_use_pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db        <= 8'h00;
            r_pix_q     <= 16'h0000;
            r_underflow <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            if (w_start)
                r_underflow <= 1'b0;
            if (w_frame_done)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_launch) begin
                if (w_act_byte) begin
                    if (w_even) begin
                        if (w_use_pat) begin
                            r_pix_q <= w_pat_pix;
                            r_db    <= w_pat_pix[15:8];
                        end else if (pix_valid) begin
                            r_pix_q <= pix_data;
                            r_db    <= pix_data[15:8];
                        end else begin
                            // starved: send black, keep line timing intact
                            r_pix_q     <= 16'h0000;
                            r_db        <= 8'h00;
                            r_underflow <= 1'b1;
                        end
                    end else begin
                        r_db <= r_pix_q[7:0];
                    end
                end else begin
                    r_db <= 8'h00;
                end
            end
        end
    end

    assign cmos_db     = r_db;
    assign frame_start = w_frame_start;
    assign underflow   = r_underflow;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- OV7670-style DVP parallel-video transmitter. It is the sending end of the pixel-capture path.
- Takes RGB565 pixels from an upstream stream (SDRAM read-back FIFO, or the sobel output FIFO).
- Drives cmos_pclk/cmos_href/cmos_vsync/cmos_db with the same timing the capture logic samples: data stable at pclk rising edge, high byte first.
- Used as a synthesizable camera model for loop-back bring-up, and to re-export processed frames off-board.

Parameters:
- H_ACTIVE, 640, active pixels per line (each pixel = 2 bytes = 2 pclk periods)
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 144, pclk periods per line with href low
- VSYNC_LINES, 3, lines with vsync high at frame start
- V_BACK, 17, blank lines after vsync, before the first active line
- V_FRONT, 10, blank lines after the last active line
- (derived) LINE_LEN = 2*H_ACTIVE + H_BLANK pclk periods

Ports:
- clk  in  1  system clock; cmos_pclk = clk/2
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; start/continue frame generation
- pix_data  in  16  RGB565 pixel, first-word-fall-through
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  one-cycle pop strobe; a pixel is consumed when pix_ready && pix_valid
- cmos_pclk  out  1  pixel clock, 50% duty, period 2 clk
- cmos_href  out  1  high during active bytes of an active line
- cmos_vsync  out  1  high for VSYNC_LINES lines at frame start
- cmos_db  out  8  byte bus
- frame_start  out  1  one-clk pulse when vsync rises
- underflow  out  1  sticky; pixel needed while pix_valid low
- frame_cnt  out  16  completed frames, wraps 16'hFFFF->0

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, pclk_q 0.
- pclk_q toggles every clk while state != IDLE; it is held 0 in IDLE.
- All of href, vsync and db update only on the clk edge where pclk_q goes 1->0 (the "launch edge"). They are therefore stable for a full clk before and after each pclk rising edge.
- Counters:
  - h_cnt counts launch edges 0..LINE_LEN-1.
  - v_cnt counts lines 0..VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT-1.
- State machine, advanced at launch edges:
  - IDLE -> VSYNC when enable=1 (first launch edge one clk after enable is seen).
  - VSYNC: vsync=1, href=0, db=0. Lasts VSYNC_LINES lines. frame_start pulses on entry.
  - VSYNC -> VBACK: V_BACK lines, all outputs low.
  - VBACK -> ACTIVE: lines V_ACTIVE.
    - h_cnt < 2*H_ACTIVE: href=1; even h_cnt launches pix[15:8], odd launches pix[7:0].
    - Remaining H_BLANK periods: href=0, db=0.
  - ACTIVE -> VFRONT: V_FRONT blank lines. At the end, frame_cnt += 1.
  - VFRONT -> VSYNC if enable=1, else -> IDLE.
- Pixel fetch:
  - pix_ready=1 for exactly the clk cycle ending in the launch edge of an even active h_cnt.
  - Pixel latched into pix_q. The low byte is taken from pix_q at the next launch edge.
  - If pix_valid=0 at that cycle: pixel 16'h0000 is sent, no pop occurs, underflow<=1. Timing is never stretched.
- underflow is cleared only on reset or on an IDLE->VSYNC transition.
- Boundary conditions:
  - enable dropped mid-frame: the current frame completes fully, then IDLE. No partial frames.
  - enable re-asserted during VFRONT: goes straight to the next VSYNC, no IDLE gap.
  - Reset mid-line: all outputs immediately 0, href/vsync never glitch high.

Optional Feature:
- Macro: DVP_TX_TEST_PATTERN_EN.
- When defined:
  - Adds input pattern_sel (1 bit), sampled at frame_start and held for the frame.
  - With pattern_sel=1, pixels come from an internal 8-vertical-bar generator: bar index = (pixel column*8)/H_ACTIVE.
  - Bar colours, in order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - pix_ready stays 0 and underflow is not set.
- When not defined: no pattern_sel port, no generator logic.

Decomposition:
- Package dvp_pkg: state encoding (IDLE, VSYNC, VBACK, ACTIVE, VFRONT) and the eight RGB565 bar constants.
- One natural sub-module, dvp_timing_gen: pclk_q, h_cnt, v_cnt, state, launch strobe.
- Top level: pixel fetch/byte mux, underflow, frame_cnt, pattern generator.

Test Plan:
Parameters for all scenarios: H_ACTIVE=4, H_BLANK=4, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives a line of 12 pclk (24 clk) and a frame of 120 clk.
1. Timing: enable=1, pixels always valid -> vsync high for exactly 24 clk. First href rise 48 clk after vsync rise. href high for 8 pclk per active line. Period from frame_start to frame_start = 120 clk.
2. Byte order/sampling: feed 16'h1234, 16'hABCD, ... -> receiver sampling at pclk rise sees 12,34,AB,CD. Each byte is stable for 1 clk on both sides of the rising edge. Exactly 4 pix_ready&&pix_valid pops per line.
3. Underflow: drop pix_valid for the 3rd pixel of line 1 -> that pixel is sent as 00,00, underflow=1 and stays 1 to the end of the frame. href timing is unchanged and the following pixel is the next FIFO word.
4. enable deasserted at clk 30 of a frame -> frame completes, frame_cnt goes 0->1, outputs idle (pclk held 0). Re-enable -> underflow cleared, frame_start pulses.
5. Reset asserted during ACTIVE with href=1 -> href, vsync, db, pclk and pix_ready are 0 in the same cycle. After release, the first frame starts with VSYNC.
6. With DVP_TX_TEST_PATTERN_EN defined and pattern_sel=1, H_ACTIVE=8 -> line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00. pix_ready is never asserted.
